// File: rtl/mirfak_pipeline_ctrl_if.sv
// Hazard-unit interface between the pipeline datapath (master) and the controller (slave).
interface mirfak_pipeline_ctrl_if;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_use_rs1_i;
    logic        id_use_rs2_i;
    logic        id_take_branch_i;
    logic [4:0]  ex_rd_i;
    logic        ex_wen_i;
    logic        ex_is_load_i;
    logic        ex_exception_i;
    logic [4:0]  wb_rd_i;
    logic        wb_wen_i;
    logic        mem_busy_i;
    logic [1:0]  id_fwd_a_sel_o;
    logic [1:0]  id_fwd_b_sel_o;
    logic        ifid_enable_o;
    logic        ifid_clear_o;
    logic        idex_enable_o;
    logic        idex_clear_o;
    logic        exwb_enable_o;
    logic        exwb_clear_o;
    logic        trap_redirect_o;
    logic [31:0] stall_count_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_take_branch_i,
               ex_rd_i, ex_wen_i, ex_is_load_i, ex_exception_i, wb_rd_i, wb_wen_i,
               mem_busy_i,
        input  id_fwd_a_sel_o, id_fwd_b_sel_o, ifid_enable_o, ifid_clear_o,
               idex_enable_o, idex_clear_o, exwb_enable_o, exwb_clear_o,
               trap_redirect_o, stall_count_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, id_take_branch_i,
               ex_rd_i, ex_wen_i, ex_is_load_i, ex_exception_i, wb_rd_i, wb_wen_i,
               mem_busy_i,
        output id_fwd_a_sel_o, id_fwd_b_sel_o, ifid_enable_o, ifid_clear_o,
               idex_enable_o, idex_clear_o, exwb_enable_o, exwb_clear_o,
               trap_redirect_o, stall_count_o
    );
endinterface

// File: rtl/mirfak_pipeline_ctrl.sv
// Three-stage pipeline hazard controller: forwarding, load-use stalls, branch and trap flushes.
// Optional stall-cycle counter enabled by defining MIRFAK_STALL_COUNTER_EN.
module mirfak_pipeline_ctrl (
    input  logic                    clk_i,
    input  logic                    rst_i,
    mirfak_pipeline_ctrl_if.slave   pif
);

    localparam logic [1:0] FwdIdSel = 2'd0;
    localparam logic [1:0] FwdExSel = 2'd1;
    localparam logic [1:0] FwdWbSel = 2'd2;

    typedef enum logic [1:0] {StRun, StFlush, StRedirect} state_e;

    state_e state_q, state_d;

    logic       ifid_en, ifid_clr, idex_en, idex_clr, exwb_en, exwb_clr, trap;
    logic [1:0] fwd_a, fwd_b;
    logic       load_use;

    // x0 is hardwired zero, so writes to it never forward or stall.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] ex_rd, input logic ex_wen,
                                           input logic [4:0] wb_rd, input logic wb_wen);
        if (ex_wen && ex_rd != 5'd0 && ex_rd == rs) begin
            return FwdExSel;
        end else if (wb_wen && wb_rd != 5'd0 && wb_rd == rs) begin
            return FwdWbSel;
        end
        return FwdIdSel;
    endfunction

    always_comb begin
        load_use = pif.ex_is_load_i && pif.ex_wen_i && (pif.ex_rd_i != 5'd0) &&
                   ((pif.id_use_rs1_i && pif.ex_rd_i == pif.id_rs1_i) ||
                    (pif.id_use_rs2_i && pif.ex_rd_i == pif.id_rs2_i));
    end

    always_comb begin
        fwd_a = FwdIdSel;
        fwd_b = FwdIdSel;
        if (!rst_i) begin
            fwd_a = fwd_sel(pif.id_rs1_i, pif.ex_rd_i, pif.ex_wen_i, pif.wb_rd_i, pif.wb_wen_i);
            fwd_b = fwd_sel(pif.id_rs2_i, pif.ex_rd_i, pif.ex_wen_i, pif.wb_rd_i, pif.wb_wen_i);
        end
    end

    always_comb begin
        state_d  = state_q;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exwb_en  = 1'b1;
        ifid_clr = 1'b0;
        idex_clr = 1'b0;
        exwb_clr = 1'b0;
        trap     = 1'b0;
        if (rst_i) begin
            state_d  = StRun;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exwb_en  = 1'b0;
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
            exwb_clr = 1'b1;
        end else if (pif.mem_busy_i) begin
            // Full freeze: nothing advances, nothing is cleared, state holds.
            ifid_en = 1'b0;
            idex_en = 1'b0;
            exwb_en = 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (pif.ex_exception_i) begin
                        ifid_clr = 1'b1;
                        idex_clr = 1'b1;
                        exwb_clr = 1'b1;
                        state_d  = StFlush;
                    end else if (load_use) begin
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        idex_clr = 1'b1;
                    end else if (pif.id_take_branch_i) begin
                        ifid_clr = 1'b1;
                    end
                end
                StFlush: begin
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exwb_en  = 1'b0;
                    ifid_clr = 1'b1;
                    idex_clr = 1'b1;
                    exwb_clr = 1'b1;
                    state_d  = StRedirect;
                end
                StRedirect: begin
                    trap    = 1'b1;
                    idex_en = 1'b0;
                    exwb_en = 1'b0;
                    state_d = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MIRFAK_STALL_COUNTER_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
        end else if (state_q == StRun && !idex_en) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign pif.stall_count_o = stall_cnt_q;
`else
    assign pif.stall_count_o = 32'd0;
`endif

    assign pif.id_fwd_a_sel_o  = fwd_a;
    assign pif.id_fwd_b_sel_o  = fwd_b;
    assign pif.ifid_enable_o   = ifid_en;
    assign pif.ifid_clear_o    = ifid_clr;
    assign pif.idex_enable_o   = idex_en;
    assign pif.idex_clear_o    = idex_clr;
    assign pif.exwb_enable_o   = exwb_en;
    assign pif.exwb_clear_o    = exwb_clr;
    assign pif.trap_redirect_o = trap;

endmodule

// File: tb/tb_mirfak_pipeline_ctrl.sv
// Scoreboard bench for mirfak_pipeline_ctrl: directed scenarios then random traffic vs. a reference model.
module tb_mirfak_pipeline_ctrl;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       use1, use2, br;
        logic [4:0] ex_rd;
        logic       ex_wen, ex_load, ex_exc;
        logic [4:0] wb_rd;
        logic       wb_wen, busy, rst;
    } stim_t;

    typedef struct {
        logic [1:0]  fa, fb;
        logic [2:0]  en;   // {ifid, idex, exwb}
        logic [2:0]  clr;  // {ifid, idex, exwb}
        logic        trap;
        logic [31:0] cnt;
        logic        cnt_known;
    } exp_t;

    logic clk;
    logic rst;
    mirfak_pipeline_ctrl_if pif ();

    mirfak_pipeline_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .pif   (pif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    // Reference model: pipeline mode is a plain string, counter a 32-bit integer.
    string       m_mode      = "RUN";
    logic [31:0] m_cnt       = 32'd0;
    logic        m_cnt_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
        if (s.ex_wen && s.ex_rd != 0 && s.ex_rd == rs) return 2'd1;
        if (s.wb_wen && s.wb_rd != 0 && s.wb_rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rs1: 5'd0, rs2: 5'd0, use1: 1'b0, use2: 1'b0, br: 1'b0, ex_rd: 5'd0,
              ex_wen: 1'b0, ex_load: 1'b0, ex_exc: 1'b0, wb_rd: 5'd0, wb_wen: 1'b0,
              busy: 1'b0, rst: 1'b0};
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        logic lu;
        @(posedge clk);
        #1;
        rst                  = s.rst;
        pif.id_rs1_i         = s.rs1;
        pif.id_rs2_i         = s.rs2;
        pif.id_use_rs1_i     = s.use1;
        pif.id_use_rs2_i     = s.use2;
        pif.id_take_branch_i = s.br;
        pif.ex_rd_i          = s.ex_rd;
        pif.ex_wen_i         = s.ex_wen;
        pif.ex_is_load_i     = s.ex_load;
        pif.ex_exception_i   = s.ex_exc;
        pif.wb_rd_i          = s.wb_rd;
        pif.wb_wen_i         = s.wb_wen;
        pif.mem_busy_i       = s.busy;

        lu = s.ex_load && s.ex_wen && s.ex_rd != 0 &&
             ((s.use1 && s.ex_rd == s.rs1) || (s.use2 && s.ex_rd == s.rs2));
        e.cnt       = m_cnt;
        e.cnt_known = m_cnt_known;
        e.trap      = 1'b0;
        e.fa        = ref_fwd(s.rs1, s);
        e.fb        = ref_fwd(s.rs2, s);
        e.en        = 3'b111;
        e.clr       = 3'b000;
        if (s.rst) begin
            e.fa = 2'd0; e.fb = 2'd0; e.en = 3'b000; e.clr = 3'b111;
            m_mode = "RUN"; m_cnt = 32'd0; m_cnt_known = 1'b1;
        end else if (s.busy) begin
            e.en = 3'b000;
            if (m_mode == "RUN") m_cnt = m_cnt + 32'd1;
        end else if (m_mode == "RUN") begin
            if (s.ex_exc) begin
                e.clr = 3'b111; m_mode = "FLUSH";
            end else if (lu) begin
                e.en = 3'b001; e.clr = 3'b010; m_cnt = m_cnt + 32'd1;
            end else if (s.br) begin
                e.clr = 3'b100;
            end
        end else if (m_mode == "FLUSH") begin
            e.en = 3'b000; e.clr = 3'b111; m_mode = "REDIRECT";
        end else begin
            e.trap = 1'b1; e.en = 3'b100; m_mode = "RUN";
        end
`ifndef MIRFAK_STALL_COUNTER_EN
        e.cnt       = 32'd0;
        e.cnt_known = 1'b1;
`endif
        sb_q.push_back(e);
    endtask

    // Monitor: compares every presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("fwd_a",     {30'd0, pif.id_fwd_a_sel_o}, {30'd0, e.fa});
                chk("fwd_b",     {30'd0, pif.id_fwd_b_sel_o}, {30'd0, e.fb});
                chk("ifid_en",   {31'd0, pif.ifid_enable_o},  {31'd0, e.en[2]});
                chk("idex_en",   {31'd0, pif.idex_enable_o},  {31'd0, e.en[1]});
                chk("exwb_en",   {31'd0, pif.exwb_enable_o},  {31'd0, e.en[0]});
                chk("ifid_clr",  {31'd0, pif.ifid_clear_o},   {31'd0, e.clr[2]});
                chk("idex_clr",  {31'd0, pif.idex_clear_o},   {31'd0, e.clr[1]});
                chk("exwb_clr",  {31'd0, pif.exwb_clear_o},   {31'd0, e.clr[0]});
                chk("trap",      {31'd0, pif.trap_redirect_o}, {31'd0, e.trap});
                if (e.cnt_known) chk("stall_count", pif.stall_count_o, e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        s = idle();
        s.rst = 1'b1;
        drive(s);
        drive(s);

        // EX beats WB on operand A.
        s = idle();
        s.rs1 = 5'd5; s.use1 = 1'b1; s.ex_rd = 5'd5; s.ex_wen = 1'b1; s.wb_rd = 5'd5; s.wb_wen = 1'b1;
        drive(s);
        // WB forwards on operand B when EX does not match.
        s = idle();
        s.rs2 = 5'd9; s.ex_rd = 5'd3; s.ex_wen = 1'b1; s.wb_rd = 5'd9; s.wb_wen = 1'b1;
        drive(s);
        // Load to x0 never stalls or forwards.
        s = idle();
        s.ex_rd = 5'd0; s.ex_wen = 1'b1; s.ex_load = 1'b1; s.rs2 = 5'd0; s.use2 = 1'b1;
        drive(s);
        // Load-use on x7, with a branch that must be ignored.
        s = idle();
        s.ex_rd = 5'd7; s.ex_wen = 1'b1; s.ex_load = 1'b1; s.rs2 = 5'd7; s.use2 = 1'b1; s.br = 1'b1;
        drive(s);
        drive(idle());
        // Plain taken branch.
        s = idle();
        s.br = 1'b1;
        drive(s);
        // Exception pulse -> flush -> redirect -> run; both ignored inputs held high.
        s = idle();
        s.ex_exc = 1'b1;
        drive(s);
        s.br = 1'b1;
        drive(s);
        drive(s);
        drive(idle());
        // Busy together with exception, then exception handled once busy drops.
        s = idle();
        s.ex_exc = 1'b1; s.busy = 1'b1;
        repeat (3) drive(s);
        s.busy = 1'b0;
        drive(s);
        repeat (3) drive(idle());
        // Exception plus load-use: exception wins.
        s = idle();
        s.ex_exc = 1'b1; s.ex_rd = 5'd4; s.ex_wen = 1'b1; s.ex_load = 1'b1; s.rs1 = 5'd4;
        s.use1 = 1'b1;
        drive(s);
        // Reset while in FLUSH.
        s = idle();
        s.rst = 1'b1;
        drive(s);
        repeat (3) drive(idle());

        for (int i = 0; i < 3000; i++) begin
            s.rs1     = 5'($urandom_range(0, 3));
            s.rs2     = 5'($urandom_range(0, 3));
            s.use1    = 1'($urandom_range(0, 1));
            s.use2    = 1'($urandom_range(0, 1));
            s.br      = ($urandom_range(0, 9) == 0);
            s.ex_rd   = 5'($urandom_range(0, 3));
            s.ex_wen  = 1'($urandom_range(0, 1));
            s.ex_load = 1'($urandom_range(0, 1));
            s.ex_exc  = ($urandom_range(0, 19) == 0);
            s.wb_rd   = 5'($urandom_range(0, 3));
            s.wb_wen  = 1'($urandom_range(0, 1));
            s.busy    = ($urandom_range(0, 6) == 0);
            s.rst     = ($urandom_range(0, 99) == 0);
            drive(s);
        end

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
